// File: rtl/alu_wide_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_wide_op_sequencer
//
// Purpose:
//   Runs 32-bit ADD/ADC/XOR/AND operations on a 16-bit ALU. The low word is
//   computed first, then the high word. The high word uses the carry that the
//   ALU latched from the low word. The two 16-bit results and the ALU flags
//   are then folded into a 32-bit result with 32-bit {Z,C,N,O} flags.
//   While an operation is in flight, this block owns the ALU write-flag
//   strobe (alu_wf).
//
// Ports:
//   clk          in   1   system clock, all state updates on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   high only when idle; accept on req_valid & req_ready
//   req_op       in   2   00 ADD32, 01 ADC32, 10 XOR32, 11 AND32
//   req_a        in   32  operand A
//   req_b        in   32  operand B
//   resp_valid   out  1   result present
//   resp_ready   in   1   consumer takes result on resp_valid & resp_ready
//   resp_data    out  32  {hi,lo} result
//   resp_flags   out  4   {Z,C,N,O} of the 32-bit operation
//   alu_a        out  16  ALU operand A
//   alu_b        out  16  ALU operand B
//   alu_fun_sel  out  5   ALU function select
//   alu_wf       out  1   ALU flag write enable
//   alu_out      in   16  ALU combinational result
//   alu_flags    in   4   ALU latched flags {Z,C,N,O}
// ----------------------------------------------------------------------------
module alu_wide_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [3:0]  resp_flags,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_fun_sel,
    output logic        alu_wf,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        FIN  = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [4:0] FS_IDLE = 5'b10000;
    localparam logic [4:0] FS_ADD  = 5'b10100;
    localparam logic [4:0] FS_ADC  = 5'b10101;
    localparam logic [4:0] FS_AND  = 5'b10111;
    localparam logic [4:0] FS_XOR  = 5'b11001;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        z_lo;

    // The low word of ADD32 must ignore the ALU's stale carry. ADC32 chains
    // that carry in.
    function automatic logic [4:0] lo_code(input logic [1:0] op);
        case (op)
            2'b00:   lo_code = FS_ADD;
            2'b01:   lo_code = FS_ADC;
            2'b10:   lo_code = FS_XOR;
            default: lo_code = FS_AND;
        endcase
    endfunction

    // The high word of both add flavours takes the carry out of the low word.
    function automatic logic [4:0] hi_code(input logic [1:0] op);
        case (op)
            2'b00,
            2'b01:   hi_code = FS_ADC;
            2'b10:   hi_code = FS_XOR;
            default: hi_code = FS_AND;
        endcase
    endfunction

    // Single sequencing FSM. The ALU drive signals are registered one state
    // ahead: the edge that enters a state loads the values that state needs.
    // Z of the full result needs both halves to be zero. The low-half Z is
    // still in the ALU flag latch at the HI edge, so it is saved then. The
    // high-half flags are read at the FIN edge, once the ALU has latched them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_lo      <= '0;
            res_hi      <= '0;
            z_lo        <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_flags  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_fun_sel <= FS_IDLE;
            alu_wf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q        <= req_op;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        alu_a       <= req_a[15:0];
                        alu_b       <= req_b[15:0];
                        alu_fun_sel <= lo_code(req_op);
                        alu_wf      <= 1'b1;
                        req_ready   <= 1'b0;
                        state       <= LO;
                    end
                end
                LO: begin
                    res_lo      <= alu_out;
                    alu_a       <= a_q[31:16];
                    alu_b       <= b_q[31:16];
                    alu_fun_sel <= hi_code(op_q);
                    state       <= HI;
                end
                HI: begin
                    res_hi      <= alu_out;
                    z_lo        <= alu_flags[3];
                    alu_a       <= '0;
                    alu_b       <= '0;
                    alu_fun_sel <= FS_IDLE;
                    alu_wf      <= 1'b0;
                    state       <= FIN;
                end
                FIN: begin
                    resp_data  <= {res_hi, res_lo};
                    resp_flags <= {z_lo & alu_flags[3], alu_flags[2:0]};
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    alu_a       <= '0;
                    alu_b       <= '0;
                    alu_fun_sel <= FS_IDLE;
                    alu_wf      <= 1'b0;
                    resp_valid  <= 1'b0;
                    req_ready   <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_wide_op_sequencer
//
// Purpose:
//   Self-checking bench for alu_wide_op_sequencer. It contains a behavioural
//   16-bit ALU: the result is combinational and the flags are latched on the
//   clock edge when WF=1. The logic ops update only Z and N. Expected 32-bit
//   results are computed with plain 32-bit arithmetic and queued when a
//   request is accepted. They are popped and compared when the response
//   appears.
// ----------------------------------------------------------------------------
module tb_alu_wide_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_flags;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_fun_sel;
    logic        alu_wf;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t expQ[$];
    int   testCount = 0;
    int   failCount = 0;
    int   wfCycles = 0;
    int   xorWfCycles = 0;
    logic modelC = 1'b0;
    logic modelO = 1'b0;

    alu_wide_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_flags  (resp_flags),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_fun_sel (alu_fun_sel),
        .alu_wf      (alu_wf),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags)
    );

    always #5 clk = ~clk;

    // Behavioural 16-bit ALU: combinational result, with ADC consuming the
    // latched carry.
    logic [16:0] aluSum;
    logic [15:0] aluOutComb;
    logic [3:0]  aluFlagReg = 4'b0000;

    always_comb begin
        aluSum     = '0;
        aluOutComb = alu_a;
        case (alu_fun_sel)
            5'b10100: begin
                aluSum     = {1'b0, alu_a} + {1'b0, alu_b};
                aluOutComb = aluSum[15:0];
            end
            5'b10101: begin
                aluSum     = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, aluFlagReg[2]};
                aluOutComb = aluSum[15:0];
            end
            5'b11001: aluOutComb = alu_a ^ alu_b;
            5'b10111: aluOutComb = alu_a & alu_b;
            default:  aluOutComb = alu_a;
        endcase
    end

    assign alu_out   = aluOutComb;
    assign alu_flags = aluFlagReg;

    // ALU flag latch. Arithmetic ops set all four flags. Logic ops keep C and O.
    always @(posedge clk) begin
        if (alu_wf) begin
            case (alu_fun_sel)
                5'b10100, 5'b10101:
                    aluFlagReg <= {aluOutComb == 16'd0, aluSum[16], aluOutComb[15],
                                   (alu_a[15] == alu_b[15]) && (aluOutComb[15] != alu_a[15])};
                5'b11001, 5'b10111:
                    aluFlagReg <= {aluOutComb == 16'd0, aluFlagReg[2], aluOutComb[15], aluFlagReg[0]};
                default: aluFlagReg <= aluFlagReg;
            endcase
        end
    end

    // Count the cycles in which the sequencer holds the ALU flag strobe.
    always @(negedge clk) begin
        if (alu_wf) begin
            wfCycles++;
            if (alu_fun_sel == 5'b11001) xorWfCycles++;
        end
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Wait for the sequencer to be idle, present one request, and queue its
    // expected 32-bit result.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        int          waitCount;
        exp_t        e;
        logic [32:0] s;
        logic        c;
        logic        o;
        waitCount = 0;
        @(negedge clk);
        while (!req_ready && waitCount < 20) begin
            @(negedge clk);
            waitCount++;
        end
        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        c = modelC;
        o = modelO;
        s = '0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                e.data = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (e.data[31] != a[31]);
            end
            2'b01: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, modelC};
                e.data = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (e.data[31] != a[31]);
            end
            2'b10:   e.data = a ^ b;
            default: e.data = a & b;
        endcase
        e.flags = {e.data == 32'd0, c, e.data[31], o};
        modelC  = c;
        modelO  = o;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        expQ.push_back(e);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, check its latency, optionally stall it while a
    // competing request is driven, then compare against the scoreboard and
    // complete the handshake.
    task automatic collectResponse(input int holdCycles);
        int          edges;
        exp_t        e;
        logic [31:0] heldData;
        logic [3:0]  heldFlags;
        // The accept edge counts as the first edge.
        edges = 1;
        while (!resp_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("resp_latency", 32'(edges), 32'd4);
        heldData  = resp_data;
        heldFlags = resp_flags;
        for (int i = 0; i < holdCycles; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b11;
            req_a     = 32'hFFFF_0000;
            req_b     = 32'h0F0F_F0F0;
            @(posedge clk);
            #1;
            checkOutput("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("hold_resp_data", resp_data, heldData);
            checkOutput("hold_resp_flags", {28'd0, resp_flags}, {28'd0, heldFlags});
            checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("resp_data", resp_data, e.data);
            checkOutput("resp_flags", {28'd0, resp_flags}, {28'd0, e.flags});
        end else begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("resp_valid_cleared", {31'd0, resp_valid}, 32'd0);
    endtask

    // Full operation with a check that the flag strobe was asserted for two cycles.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int holdCycles);
        int wfBefore;
        wfBefore = wfCycles;
        applyStimulus(op, a, b);
        collectResponse(holdCycles);
        checkOutput("alu_wf_cycles", 32'(wfCycles - wfBefore), 32'd2);
    endtask

    initial begin
        int xorBefore;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset_resp_data", resp_data, 32'd0);
        checkOutput("reset_resp_flags", {28'd0, resp_flags}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_alu_wf", {31'd0, alu_wf}, 32'd0);
        checkOutput("reset_fun_sel", {27'd0, alu_fun_sel}, 32'h10);

        runOp(2'b00, 32'h0001_FFFF, 32'h0000_0001, 0);
        runOp(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        // Carry is left set by the previous op.
        runOp(2'b01, 32'h0000_0000, 32'h0000_0000, 0);
        runOp(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 0);

        xorBefore = xorWfCycles;
        runOp(2'b10, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 0);
        checkOutput("xor_fun_sel_cycles", 32'(xorWfCycles - xorBefore), 32'd2);

        runOp(2'b11, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        for (int i = 0; i < 6; i++) begin
            runOp(2'($urandom_range(0, 3)), $urandom, $urandom, 0);
        end

        // A stalled consumer must see a stable response while a competing
        // request is ignored.
        runOp(2'b00, 32'h1234_5678, 32'h1111_1111, 3);

        // Reset asserted while the high word is in flight.
        applyStimulus(2'b00, 32'h0000_8000, 32'h0000_8000);
        @(posedge clk);
        #2;
        checkOutput("hi_alu_wf", {31'd0, alu_wf}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midreset_resp_data", resp_data, 32'd0);
        checkOutput("midreset_resp_flags", {28'd0, resp_flags}, 32'd0);
        checkOutput("midreset_alu_wf", {31'd0, alu_wf}, 32'd0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        runOp(2'b00, 32'h8000_0000, 32'h8000_0000, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
